// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, funct, ALU and control encodings
// Purpose: common constants and enums for the fetch, decode and execute stages.
// Ports:   none (package).
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   // Primary opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes, instr[5:0]
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD      = 4'd0,
      ALU_SUB      = 4'd1,
      ALU_AND      = 4'd2,
      ALU_OR       = 4'd3,
      ALU_XOR      = 4'd4,
      ALU_NOR      = 4'd5,
      ALU_SLT      = 4'd6,
      ALU_SLTU     = 4'd7,
      ALU_SLL      = 4'd8,
      ALU_SRL      = 4'd9,
      ALU_SRA      = 4'd10,
      ALU_LUI      = 4'd11,
      ALU_PASS_PC8 = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_BEQ  = 2'b01,
      BR_BNE  = 2'b10
   } branch_e;

   typedef enum logic [1:0] {
      JMP_NONE   = 2'b00,
      JMP_TARGET = 2'b01,
      JMP_REG    = 2'b10
   } jump_e;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read 1-write register file with write-through bypass
// Purpose: architectural registers; $0 reads as zero and ignores writes.
// Ports:   clock/reset; rd_addr_a/b -> rd_data_a/b (combinational);
//          wr_en/wr_addr/wr_data write on posedge.
module regfile_2r1w
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem_q [2**REG_AW];
   logic [DATA_W-1:0] mem_d [2**REG_AW];

   always_comb begin
      mem_d = mem_q;
      if (wr_en && (wr_addr != '0)) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // A write landing in the same cycle is visible to the reader, so decode
   // never sees a stale value for a result retiring this cycle.
   assign rd_data_a = (rd_addr_a == '0) ? '0 :
                      (wr_en && (wr_addr == rd_addr_a)) ? wr_data : mem_q[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0) ? '0 :
                      (wr_en && (wr_addr == rd_addr_b)) ? wr_data : mem_q[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS decode stage: field split, control, operands, hazard bubble
// Purpose: decodes one fetched instruction per cycle into a registered bundle for execute.
// Ports:   clock/reset; i_valid/i_instr/i_pc/i_ready from fetch; flush from execute;
//          wb_en/wb_addr/wb_data register writeback; ex_ready and d_* bundle to execute.
module decode_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [31:0]       i_instr,
   input  logic [31:0]       i_pc,
   output logic              i_ready,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_ready,
   output logic              d_valid,
   output logic [31:0]       d_pc,
   output logic [DATA_W-1:0] d_rs_data,
   output logic [DATA_W-1:0] d_rt_data,
   output logic [DATA_W-1:0] d_imm,
   output logic [4:0]        d_shamt,
   output logic [REG_AW-1:0] d_dest,
   output logic [3:0]        d_alu_op,
   output logic              d_alu_imm,
   output logic              d_mem_read,
   output logic              d_mem_write,
   output logic              d_reg_write,
   output logic [1:0]        d_branch,
   output logic [1:0]        d_jump,
   output logic              d_illegal
);

   // Instruction fields
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [REG_AW-1:0] rs_idx;
   logic [REG_AW-1:0] rt_idx;
   logic [REG_AW-1:0] rd_idx;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;

   assign opcode = i_instr[31:26];
   assign funct  = i_instr[5:0];
   assign rs_idx = REG_AW'(i_instr[25:21]);
   assign rt_idx = REG_AW'(i_instr[20:16]);
   assign rd_idx = REG_AW'(i_instr[15:11]);
   assign imm16  = i_instr[15:0];

   regfile_2r1w #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clock     (clock),
      .reset     (reset),
      .rd_addr_a (rs_idx),
      .rd_data_a (rs_val),
      .rd_addr_b (rt_idx),
      .rd_data_b (rt_val),
      .wr_en     (wb_en),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data)
   );

   // Combinational decode
   logic [REG_AW-1:0] dec_dest;
   alu_op_e           dec_alu_op;
   logic              dec_alu_imm;
   logic              dec_mem_read;
   logic              dec_mem_write;
   logic              dec_reg_write;
   branch_e           dec_branch;
   jump_e             dec_jump;
   logic              dec_illegal;
   logic              dec_uses_rt;
   logic [DATA_W-1:0] dec_imm;

   always_comb begin
      dec_dest      = '0;
      dec_alu_op    = ALU_ADD;
      dec_alu_imm   = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_reg_write = 1'b0;
      dec_branch    = BR_NONE;
      dec_jump      = JMP_NONE;
      dec_illegal   = 1'b0;
      dec_uses_rt   = 1'b0;
      dec_imm       = {{(DATA_W-16){imm16[15]}}, imm16};

      case (opcode)
         OP_RTYPE: begin
            dec_dest      = rd_idx;
            dec_reg_write = 1'b1;
            dec_uses_rt   = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: dec_alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: dec_alu_op = ALU_SUB;
               FN_AND:          dec_alu_op = ALU_AND;
               FN_OR:           dec_alu_op = ALU_OR;
               FN_XOR:          dec_alu_op = ALU_XOR;
               FN_NOR:          dec_alu_op = ALU_NOR;
               FN_SLT:          dec_alu_op = ALU_SLT;
               FN_SLTU:         dec_alu_op = ALU_SLTU;
               FN_SLL:          dec_alu_op = ALU_SLL;
               FN_SRL:          dec_alu_op = ALU_SRL;
               FN_SRA:          dec_alu_op = ALU_SRA;
               FN_JR: begin
                  dec_reg_write = 1'b0;
                  dec_uses_rt   = 1'b0;
                  dec_jump      = JMP_REG;
               end
               default: begin
                  dec_dest      = '0;
                  dec_reg_write = 1'b0;
                  dec_illegal   = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
         end
         OP_SLTI: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_alu_op    = ALU_SLT;
         end
         OP_SLTIU: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_alu_op    = ALU_SLTU;
         end
         OP_ANDI: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_alu_op    = ALU_AND;
            dec_imm       = DATA_W'(imm16);
         end
         OP_ORI: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_alu_op    = ALU_OR;
            dec_imm       = DATA_W'(imm16);
         end
         OP_XORI: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_alu_op    = ALU_XOR;
            dec_imm       = DATA_W'(imm16);
         end
         OP_LUI: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_alu_op    = ALU_LUI;
            dec_imm       = DATA_W'({imm16, 16'h0000});
         end
         OP_LW: begin
            dec_dest      = rt_idx;
            dec_reg_write = 1'b1;
            dec_alu_imm   = 1'b1;
            dec_mem_read  = 1'b1;
         end
         OP_SW: begin
            dec_dest      = rt_idx;
            dec_alu_imm   = 1'b1;
            dec_mem_write = 1'b1;
            dec_uses_rt   = 1'b1;
         end
         OP_BEQ: begin
            dec_dest    = rt_idx;
            dec_alu_op  = ALU_SUB;
            dec_branch  = BR_BEQ;
            dec_uses_rt = 1'b1;
         end
         OP_BNE: begin
            dec_dest    = rt_idx;
            dec_alu_op  = ALU_SUB;
            dec_branch  = BR_BNE;
            dec_uses_rt = 1'b1;
         end
         OP_J: begin
            dec_jump = JMP_TARGET;
            dec_imm  = DATA_W'({i_pc[31:28], i_instr[25:0], 2'b00});
         end
         OP_JAL: begin
            dec_jump      = JMP_TARGET;
            dec_imm       = DATA_W'({i_pc[31:28], i_instr[25:0], 2'b00});
            dec_dest      = REG_AW'(31);
            dec_reg_write = 1'b1;
            dec_alu_op    = ALU_PASS_PC8;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase

      // $0 is a sink; nothing downstream should treat it as a real write.
      if (dec_dest == '0) begin
         dec_reg_write = 1'b0;
      end
   end

   // Output pipeline register
   logic              valid_q,     valid_d;
   logic [31:0]       pc_q,        pc_d;
   logic [DATA_W-1:0] rs_data_q,   rs_data_d;
   logic [DATA_W-1:0] rt_data_q,   rt_data_d;
   logic [DATA_W-1:0] imm_q,       imm_d;
   logic [4:0]        shamt_q,     shamt_d;
   logic [REG_AW-1:0] dest_q,      dest_d;
   logic [3:0]        alu_op_q,    alu_op_d;
   logic              alu_imm_q,   alu_imm_d;
   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              reg_write_q, reg_write_d;
   logic [1:0]        branch_q,    branch_d;
   logic [1:0]        jump_q,      jump_d;
   logic              illegal_q,   illegal_d;

   logic hazard;
   logic load;
   logic take;

   // A load in the output register cannot forward to its immediate consumer,
   // so the consumer waits one cycle while a bubble goes down the pipe.
   assign hazard = valid_q & mem_read_q & (dest_q != '0) &
                   ((dest_q == rs_idx) | ((dest_q == rt_idx) & dec_uses_rt));

   assign i_ready = (~hazard & (~valid_q | ex_ready)) | flush;
   assign load    = flush | ~valid_q | ex_ready;
   // Under flush the input is consumed but never reaches execute.
   assign take    = i_valid & i_ready & ~flush;

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_d       = imm_q;
      shamt_d     = shamt_q;
      dest_d      = dest_q;
      alu_op_d    = alu_op_q;
      alu_imm_d   = alu_imm_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      reg_write_d = reg_write_q;
      branch_d    = branch_q;
      jump_d      = jump_q;
      illegal_d   = illegal_q;

      if (load) begin
         if (take) begin
            valid_d     = 1'b1;
            pc_d        = i_pc;
            rs_data_d   = rs_val;
            rt_data_d   = rt_val;
            imm_d       = dec_imm;
            shamt_d     = i_instr[10:6];
            dest_d      = dec_dest;
            alu_op_d    = dec_alu_op;
            alu_imm_d   = dec_alu_imm;
            mem_read_d  = dec_mem_read;
            mem_write_d = dec_mem_write;
            reg_write_d = dec_reg_write;
            branch_d    = dec_branch;
            jump_d      = dec_jump;
            illegal_d   = dec_illegal;
         end else begin
            // Bubble: fully zeroed so a stray control bit can never leak.
            valid_d     = 1'b0;
            pc_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            shamt_d     = '0;
            dest_d      = '0;
            alu_op_d    = '0;
            alu_imm_d   = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
            branch_d    = '0;
            jump_d      = '0;
            illegal_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         shamt_q     <= '0;
         dest_q      <= '0;
         alu_op_q    <= '0;
         alu_imm_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_write_q <= 1'b0;
         branch_q    <= '0;
         jump_q      <= '0;
         illegal_q   <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         shamt_q     <= shamt_d;
         dest_q      <= dest_d;
         alu_op_q    <= alu_op_d;
         alu_imm_q   <= alu_imm_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         reg_write_q <= reg_write_d;
         branch_q    <= branch_d;
         jump_q      <= jump_d;
         illegal_q   <= illegal_d;
      end
   end

   assign d_valid     = valid_q;
   assign d_pc        = pc_q;
   assign d_rs_data   = rs_data_q;
   assign d_rt_data   = rt_data_q;
   assign d_imm       = imm_q;
   assign d_shamt     = shamt_q;
   assign d_dest      = dest_q;
   assign d_alu_op    = alu_op_q;
   assign d_alu_imm   = alu_imm_q;
   assign d_mem_read  = mem_read_q;
   assign d_mem_write = mem_write_q;
   assign d_reg_write = reg_write_q;
   assign d_branch    = branch_q;
   assign d_jump      = jump_q;
   assign d_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;
   import mips_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [31:0] i_instr;
   logic [31:0] i_pc;
   logic        i_ready;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_ready;
   logic        d_valid;
   logic [31:0] d_pc;
   logic [31:0] d_rs_data;
   logic [31:0] d_rt_data;
   logic [31:0] d_imm;
   logic [4:0]  d_shamt;
   logic [4:0]  d_dest;
   logic [3:0]  d_alu_op;
   logic        d_alu_imm;
   logic        d_mem_read;
   logic        d_mem_write;
   logic        d_reg_write;
   logic [1:0]  d_branch;
   logic [1:0]  d_jump;
   logic        d_illegal;

   always #5 clock = ~clock;

   decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clock(clock), .reset(reset),
      .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc), .i_ready(i_ready),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_ready(ex_ready), .d_valid(d_valid), .d_pc(d_pc),
      .d_rs_data(d_rs_data), .d_rt_data(d_rt_data), .d_imm(d_imm),
      .d_shamt(d_shamt), .d_dest(d_dest), .d_alu_op(d_alu_op),
      .d_alu_imm(d_alu_imm), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_reg_write(d_reg_write), .d_branch(d_branch), .d_jump(d_jump),
      .d_illegal(d_illegal)
   );

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        valid;
      logic [31:0] pc, rs, rt, imm;
      logic [4:0]  shamt, dest;
      logic [3:0]  alu;
      logic        alu_imm, mr, mw, rw;
      logic [1:0]  br, jp;
      logic        ill;
   } bundle_t;

   bundle_t     m;
   logic [31:0] rf [32];

   function automatic string mnemonic(input logic [31:0] ins);
      string s;
      s = "";
      if (ins[31:26] == 6'd0) begin
         case (ins[5:0])
            6'h20: s = "add";  6'h21: s = "addu"; 6'h22: s = "sub";  6'h23: s = "subu";
            6'h24: s = "and";  6'h25: s = "or";   6'h26: s = "xor";  6'h27: s = "nor";
            6'h2A: s = "slt";  6'h2B: s = "sltu"; 6'h00: s = "sll";  6'h02: s = "srl";
            6'h03: s = "sra";  6'h08: s = "jr";
            default: s = "";
         endcase
      end else begin
         case (ins[31:26])
            6'h08: s = "addi"; 6'h09: s = "addiu"; 6'h0A: s = "slti"; 6'h0B: s = "sltiu";
            6'h0C: s = "andi"; 6'h0D: s = "ori";   6'h0E: s = "xori"; 6'h0F: s = "lui";
            6'h23: s = "lw";   6'h2B: s = "sw";    6'h04: s = "beq";  6'h05: s = "bne";
            6'h02: s = "j";    6'h03: s = "jal";
            default: s = "";
         endcase
      end
      return s;
   endfunction

   function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
      bundle_t     r;
      string       nm;
      logic [15:0] k;
      nm = mnemonic(ins);
      k  = ins[15:0];
      r  = '{default: 0};
      r.valid = 1'b1;
      r.pc    = pc;
      r.rs    = a;
      r.rt    = b;
      r.shamt = ins[10:6];
      r.ill   = (nm == "");
      case (nm)
         "sub", "subu", "beq", "bne": r.alu = ALU_SUB;
         "and", "andi":               r.alu = ALU_AND;
         "or", "ori":                 r.alu = ALU_OR;
         "xor", "xori":               r.alu = ALU_XOR;
         "nor":                       r.alu = ALU_NOR;
         "slt", "slti":               r.alu = ALU_SLT;
         "sltu", "sltiu":             r.alu = ALU_SLTU;
         "sll":                       r.alu = ALU_SLL;
         "srl":                       r.alu = ALU_SRL;
         "sra":                       r.alu = ALU_SRA;
         "lui":                       r.alu = ALU_LUI;
         "jal":                       r.alu = ALU_PASS_PC8;
         default:                     r.alu = ALU_ADD;
      endcase
      case (nm)
         "addi", "addiu", "slti", "sltiu", "andi", "ori", "xori", "lui", "lw", "sw":
            r.alu_imm = 1'b1;
         default: r.alu_imm = 1'b0;
      endcase
      if (nm == "" || nm == "j")       r.dest = 5'd0;
      else if (nm == "jal")            r.dest = 5'd31;
      else if (ins[31:26] == 6'd0)     r.dest = ins[15:11];
      else                             r.dest = ins[20:16];
      r.mr = (nm == "lw");
      r.mw = (nm == "sw");
      r.br = (nm == "beq") ? 2'd1 : (nm == "bne") ? 2'd2 : 2'd0;
      r.jp = (nm == "j" || nm == "jal") ? 2'd1 : (nm == "jr") ? 2'd2 : 2'd0;
      case (nm)
         "", "sw", "beq", "bne", "j", "jr": r.rw = 1'b0;
         default:                           r.rw = (r.dest != 5'd0);
      endcase
      case (nm)
         "andi", "ori", "xori": r.imm = {16'h0000, k};
         "lui":                 r.imm = {k, 16'h0000};
         "j", "jal":            r.imm = {pc[31:28], ins[25:0], 2'b00};
         default:               r.imm = {{16{k[15]}}, k};
      endcase
      return r;
   endfunction

   function automatic logic [31:0] mrd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return rf[a];
   endfunction

   function automatic logic m_iready();
      string nm;
      logic  urt, haz;
      nm  = mnemonic(i_instr);
      urt = (i_instr[31:26] == 6'd0 && nm != "jr") || nm == "sw" || nm == "beq" || nm == "bne";
      haz = m.valid && m.mr && (m.dest != 5'd0) &&
            ((m.dest == i_instr[25:21]) || ((m.dest == i_instr[20:16]) && urt));
      return (!haz && (!m.valid || ex_ready)) || flush;
   endfunction

   always @(posedge clock) begin
      logic        rdy;
      logic [31:0] a, b;
      if (reset) begin
         m = '{default: 0};
         for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      end else begin
         rdy = m_iready();
         a   = mrd(i_instr[25:21]);
         b   = mrd(i_instr[20:16]);
         if (flush || !m.valid || ex_ready) begin
            if (i_valid && rdy && !flush) m = ref_decode(i_instr, i_pc, a, b);
            else                          m = '{default: 0};
         end
         if (wb_en && wb_addr != 5'd0) rf[wb_addr] = wb_data;
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         chk("d_valid",     32'(d_valid),     32'(m.valid));
         chk("d_pc",        d_pc,             m.pc);
         chk("d_rs_data",   d_rs_data,        m.rs);
         chk("d_rt_data",   d_rt_data,        m.rt);
         chk("d_imm",       d_imm,            m.imm);
         chk("d_shamt",     32'(d_shamt),     32'(m.shamt));
         chk("d_dest",      32'(d_dest),      32'(m.dest));
         chk("d_alu_op",    32'(d_alu_op),    32'(m.alu));
         chk("d_alu_imm",   32'(d_alu_imm),   32'(m.alu_imm));
         chk("d_mem_read",  32'(d_mem_read),  32'(m.mr));
         chk("d_mem_write", 32'(d_mem_write), 32'(m.mw));
         chk("d_reg_write", 32'(d_reg_write), 32'(m.rw));
         chk("d_branch",    32'(d_branch),    32'(m.br));
         chk("d_jump",      32'(d_jump),      32'(m.jp));
         chk("d_illegal",   32'(d_illegal),   32'(m.ill));
         chk("i_ready",     32'(i_ready),     32'(m_iready()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic er);
      i_valid  = v;
      i_instr  = ins;
      i_pc     = pc;
      ex_ready = er;
      flush    = 1'b0;
      wb_en    = 1'b0;
   endtask

   logic [5:0] r_fn [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                             6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
   logic [5:0] i_op [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                             6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};

   function automatic logic [31:0] gen_instr();
      logic [4:0]  rs, rt, rd;
      logic [31:0] raw;
      int          c;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      raw = $urandom;
      c   = $urandom_range(0, 11);
      if (c < 4)       return {6'h00, rs, rt, rd, raw[10:6], r_fn[$urandom_range(0, 13)]};
      else if (c < 7)  return {i_op[$urandom_range(0, 11)], rs, rt, raw[15:0]};
      else if (c < 9)  return {6'h23, rs, rt, raw[15:0]};
      else if (c == 9) return {($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, raw[25:0]};
      else             return raw;
   endfunction

   initial begin
      reset = 1'b1;
      put(1'b0, 32'd0, 32'd0, 1'b1);
      wb_addr = 5'd0;
      wb_data = 32'd0;
      tick();
      tick();
      check_en = 1'b1;
      chk("reset_d_valid", 32'(d_valid), 32'd0);
      chk("reset_d_imm", d_imm, 32'd0);
      reset = 1'b0;

      // addiu $8,$0,5
      put(1'b1, 32'h24080005, 32'h00000100, 1'b1);
      tick();
      chk("t1_model_imm", m.imm, 32'd5);
      chk("t1_valid", 32'(d_valid), 32'd1);
      chk("t1_dest", 32'(d_dest), 32'd8);
      chk("t1_imm", d_imm, 32'd5);
      chk("t1_alu_imm", 32'(d_alu_imm), 32'd1);
      chk("t1_alu_op", 32'(d_alu_op), 32'(ALU_ADD));
      chk("t1_reg_write", 32'(d_reg_write), 32'd1);

      // add $10,$9,$9 with same-cycle writeback of $9
      put(1'b1, 32'h01295020, 32'h00000104, 1'b1);
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
      tick();
      wb_en = 1'b0;
      chk("t2_rs", d_rs_data, 32'hDEADBEEF);
      chk("t2_rt", d_rt_data, 32'hDEADBEEF);
      chk("t2_dest", 32'(d_dest), 32'd10);

      // lw $8 then dependent add $9,$8,$8
      put(1'b1, 32'h8C880000, 32'h00000108, 1'b1);
      tick();
      chk("t3_lw_mem_read", 32'(d_mem_read), 32'd1);
      put(1'b1, 32'h01084820, 32'h0000010C, 1'b1);
      #1 chk("t3_iready_stall", 32'(i_ready), 32'd0);
      tick();
      chk("t3_bubble", 32'(d_valid), 32'd0);
      chk("t3_iready_resume", 32'(i_ready), 32'd1);
      tick();
      chk("t3_add_valid", 32'(d_valid), 32'd1);
      chk("t3_add_dest", 32'(d_dest), 32'd9);

      // stall for 3 cycles, then flush with a pending input
      put(1'b1, 32'h24080007, 32'h00000110, 1'b1);
      tick();
      put(1'b1, 32'h240900AA, 32'h00000114, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1 chk("t4_iready_stall", 32'(i_ready), 32'd0);
         tick();
         chk("t4_hold_pc", d_pc, 32'h00000110);
         chk("t4_hold_imm", d_imm, 32'd7);
      end
      flush = 1'b1;
      #1 chk("t4_iready_flush", 32'(i_ready), 32'd1);
      tick();
      chk("t4_flush_valid", 32'(d_valid), 32'd0);
      put(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      chk("t4_dropped", 32'(d_valid), 32'd0);

      // $0 write ignored, lui / ori immediates
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      tick();
      put(1'b1, 32'h3C01ABCD, 32'h00000120, 1'b1);
      tick();
      chk("t5_lui_rs", d_rs_data, 32'd0);
      chk("t5_lui_imm", d_imm, 32'hABCD0000);
      chk("t5_lui_alu", 32'(d_alu_op), 32'(ALU_LUI));
      put(1'b1, 32'h3421FFFF, 32'h00000124, 1'b1);
      tick();
      chk("t5_ori_imm", d_imm, 32'h0000FFFF);

      // jal target composition
      put(1'b1, 32'h0C000010, 32'h70000128, 1'b1);
      tick();
      chk("jal_imm", d_imm, 32'h70000040);
      chk("jal_dest", 32'(d_dest), 32'd31);
      chk("jal_alu", 32'(d_alu_op), 32'(ALU_PASS_PC8));

      // reset with a valid bundle, then registers read zero, then illegal
      reset = 1'b1;
      put(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      reset = 1'b0;
      chk("t6_reset_valid", 32'(d_valid), 32'd0);
      put(1'b1, 32'h01295020, 32'h00000130, 1'b1);
      tick();
      chk("t6_reg_cleared", d_rs_data, 32'd0);
      put(1'b1, 32'hFC000000, 32'h00000134, 1'b1);
      tick();
      chk("t6_illegal", 32'(d_illegal), 32'd1);
      chk("t6_ill_reg_write", 32'(d_reg_write), 32'd0);
      chk("t6_ill_valid", 32'(d_valid), 32'd1);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom_range(0, 199) == 0);
         i_valid  = ($urandom_range(0, 3) != 0);
         i_instr  = gen_instr();
         i_pc     = {$urandom, 2'b00} >> 2 << 2;
         ex_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         wb_en    = ($urandom_range(0, 1) == 0);
         wb_addr  = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         tick();
      end
      reset = 1'b0;

      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
